// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB slice first,
// and publishes S/Cout/V together with a one-cycle done pulse.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("digit_serial_adder: WIDTH must be 1..64 and an exact multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, psum, psum_next;
  logic             sub_q, carry;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic [DIGIT-1:0] dig_s;
  logic             dig_c, msb_cin, b_bit;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));

  // One DIGIT-wide ripple slice; msb_cin keeps the carry into the slice's top bit for V.
  always_comb begin
    dig_s   = '0;
    dig_c   = carry;
    msb_cin = carry;
    b_bit   = 1'b0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      msb_cin  = dig_c;
      b_bit    = b_q[i] ^ sub_q;
      dig_s[i] = a_q[i] ^ b_bit ^ dig_c;
      dig_c    = (a_q[i] & b_bit) | (a_q[i] & dig_c) | (b_bit & dig_c);
    end
    psum_next = WIDTH'({dig_s, psum} >> DIGIT);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Operand capture, slice shifting and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      psum  <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      V     <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      psum  <= '0;
      sub_q <= Sub;
      carry <= Cin ^ Sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      psum  <= psum_next;
      carry <= dig_c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        S    <= psum_next;
        Cout <= dig_c;
        V    <= msb_cin ^ dig_c;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: directed vectors on an 8-bit/2-bit-digit instance and a 1-bit instance.
module tb_digit_serial_adder;

  localparam int N8 = 4;
  localparam int N1 = 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       v;
  } vec_t;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic cout;
    logic v;
  } vec1_t;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       v;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, sub8, busy8, done8, cout8, v8;
  logic [7:0] a8, b8, s8;
  logic       start1, cin1, sub1, busy1, done1, cout1, v1;
  logic [0:0] a1, b1, s1;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q1[$];
  logic [7:0] prev8 = '0;
  logic       prev1 = 1'b0;
  vec_t       vecs[11];
  vec1_t      tt[8];

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8), .Sub(sub8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .V(v8)
  );

  digit_serial_adder #(.WIDTH(1), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1), .Sub(sub1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .V(v1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      prev8 = '0;
    end else begin
      if (busy8) chk("s8_hold_in_run", 64'(s8), 64'(prev8));
      if (done8) begin
        chk("busy8_low_in_done", 64'(busy8), 64'd0);
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done8_unexpected: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q8.pop_front();
          chk("s8", 64'(s8), 64'(e.s));
          chk("cout8", 64'(cout8), 64'(e.cout));
          chk("v8", 64'(v8), 64'(e.v));
          chk("done8_cycle", 64'(cyc), 64'(e.cyc));
          prev8 = e.s;
        end
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      prev1 = 1'b0;
    end else begin
      if (busy1) chk("s1_hold_in_run", 64'(s1), 64'(prev1));
      if (done1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done1_unexpected: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("s1", 64'(s1), 64'(e.s[0]));
          chk("cout1", 64'(cout1), 64'(e.cout));
          chk("v1", 64'(v1), 64'(e.v));
          chk("done1_cycle", 64'(cyc), 64'(e.cyc));
          prev1 = e.s[0];
        end
      end
    end
  end

  task automatic run1(input vec1_t t);
    exp_t e;
    a1 = t.a; b1 = t.b; cin1 = t.cin; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    e.s = {7'd0, t.s}; e.cout = t.cout; e.v = t.v; e.cyc = cyc + N1;
    q1.push_back(e);
    chk("busy1_after_accept", 64'(busy1), 64'd1);
    start1 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  // hold=1 keeps start high so the next call is accepted straight out of DONE.
  task automatic run8(input vec_t t, input bit hold);
    exp_t e;
    a8 = t.a; b8 = t.b; cin8 = t.cin; sub8 = t.sub; start8 = 1'b1;
    @(posedge clk); #1;
    e.s = t.s; e.cout = t.cout; e.v = t.v; e.cyc = cyc + N8;
    q8.push_back(e);
    chk("busy8_after_accept", 64'(busy8), 64'd1);
    start8 = hold;
    repeat (N8) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      @(posedge clk); #1;
    end
    if (!hold) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //            a      b     cin   sub   s     cout  v
    vecs[0]  = {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = {8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2]  = {8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3]  = {8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4]  = {8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
    vecs[5]  = {8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};
    vecs[6]  = {8'hC8, 8'h9C, 1'b0, 1'b0, 8'h64, 1'b1, 1'b1};
    vecs[7]  = {8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8]  = {8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[9]  = {8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[10] = {8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
    //          a     b     cin   s     cout  v
    tt[0] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tt[2] = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tt[3] = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tt[4] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tt[5] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tt[6] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tt[7] = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_s8", 64'(s8), 64'd0);
    chk("rst_cout8", 64'(cout8), 64'd0);
    chk("rst_v8", 64'(v8), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run1(tt[i]);

    for (int i = 0; i < 5; i++) run8(vecs[i], 1'b0);

    for (int i = 5; i < 9; i++) run8(vecs[i], 1'b1);
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_b2b_busy8", 64'(busy8), 64'd0);

    // Abort on the second RUN cycle; no result may ever appear for it.
    a8 = vecs[9].a; b8 = vecs[9].b; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy8", 64'(busy8), 64'd0);
    chk("abort_done8", 64'(done8), 64'd0);
    chk("abort_s8", 64'(s8), 64'd0);
    chk("abort_cout8", 64'(cout8), 64'd0);
    chk("abort_v8", 64'(v8), 64'd0);
    rst = 1'b0;
    run8(vecs[10], 1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal values 1 to 64.
REQ-002 Parameter DIGIT, default 1, bits added per clock; SHALL divide WIDTH exactly, and elaboration SHALL fail otherwise.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new operation; sampled only while busy=0.
REQ-006 A  input  WIDTH  operand A; captured when start is accepted.
REQ-007 B  input  WIDTH  operand B; captured when start is accepted.
REQ-008 Cin  input  1  carry-in when Sub=0; borrow-in when Sub=1; captured when start is accepted.
REQ-009 Sub  input  1  mode select: 0 selects add, 1 selects subtract; captured when start is accepted.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  single-cycle pulse marking valid new results.
REQ-012 S  output  WIDTH  sum or difference.
REQ-013 Cout  output  1  carry-out; when Sub=1, SHALL equal NOT(borrow-out).
REQ-014 V  output  1  two's-complement signed overflow.

Function
REQ-015 Add mode SHALL compute {Cout,S} = A + B + Cin.
REQ-016 Subtract mode SHALL compute A + ~B + ~Cin, giving S = A - B - Cin mod 2^WIDTH.
REQ-017 V SHALL equal the carry into the MSB XOR the carry out of the MSB of the operation actually performed.
REQ-018 The FSM SHALL have three states: IDLE, RUN, DONE; IDLE is the reset state.
REQ-019 Start is accepted at a rising edge where start=1 and the state is IDLE or DONE; at that edge the block SHALL capture A, B, Cin and Sub, clear the digit counter, and enter RUN.
REQ-020 busy SHALL be 1 exactly while the state is RUN.
REQ-021 In RUN, each edge SHALL add one DIGIT-bit slice, LSB slice first, using a registered carry.
REQ-022 Operation length: N = WIDTH/DIGIT edges after acceptance.
REQ-023 At the Nth edge the block SHALL update S, Cout and V together and enter DONE.
REQ-024 Latency: results and done=1 SHALL be visible N cycles after the accepting edge.
REQ-025 done SHALL be 1 only in DONE, and DONE SHALL last exactly one cycle.
REQ-026 From DONE, the next edge SHALL go to RUN if start=1 (back-to-back operation), otherwise to IDLE.
REQ-027 start, A, B, Cin and Sub SHALL be ignored while busy=1, and input changes during RUN SHALL not affect the result.
REQ-028 S, Cout and V SHALL hold their last values from completion until the next completion, including throughout RUN.
REQ-029 The partial sum SHALL be kept in an internal shift register and never driven onto S before completion.
REQ-030 With DIGIT=WIDTH, N=1: the block SHALL take a single RUN cycle, and done SHALL appear one cycle after acceptance.

Reset
REQ-031 While rst=1 at an edge: state SHALL be IDLE, and busy, done, S, Cout, V and all internal registers SHALL be 0.
REQ-032 rst SHALL take priority over start.
REQ-033 Reset during RUN SHALL abort the operation: no done pulse and no partial result on S.
REQ-034 The first edge with rst=0 SHALL be able to accept start.

Verification
REQ-035 WIDTH=1, DIGIT=1, all 8 combinations of A/B/Cin with Sub=0 -> S/Cout match the full-adder truth table, e.g. 1,1,1 -> S=1, Cout=1; done 1 cycle after accept.
REQ-036 WIDTH=8, DIGIT=2: A=8'hFF, B=8'h01, Cin=0, Sub=0 -> S=8'h00, Cout=1, V=0, done exactly 4 cycles after accept; A=8'h7F, B=8'h01 -> S=8'h80, Cout=0, V=1.
REQ-037 WIDTH=8, DIGIT=2, Sub=1: A=8'h05, B=8'h07, Cin=0 -> S=8'hFE, Cout=0, V=0; A=8'h80, B=8'h01, Cin=0 -> S=8'h7F, Cout=1, V=1; A=8'h10, B=8'h01, Cin=1 -> S=8'h0E, Cout=1.
REQ-038 start held high continuously, with A/B randomised every cycle during RUN -> each result uses only operands at its accepting edge, operations run back-to-back, and done pulses every 5 cycles (DIGIT=2, WIDTH=8).
REQ-039 rst asserted on the 2nd RUN cycle -> next cycle busy=0, done=0, S=0, Cout=0, V=0, with no later done; a fresh start of 8'h01+8'h02 -> S=8'h03.
REQ-040 S is checked every cycle during RUN -> S stays equal to the previous result until done.
